control_sequencer: RTL

- Moore FSM that sequences the Mini-SRC single-bus datapath through fetch (T0–T2) and per-opcode execute steps.
- Drives every bus-select, register-enable, ALU-op and memory strobe; reads back only IR and the CON flag.
- Sits beside the datapath; the datapath receives no other control source.

---
 rtl/control_sequencer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM sequencing the Mini-SRC single-bus datapath through fetch and per-opcode execute steps.
// Ports: clock/clear (sync active-low reset); IR (opcode in IR[31:27]), CON (branch flag), stop (halt request in T0);
// run/illegal status; alu_op; bus source selects (*out, Cout); register load enables (*in); IncPC; Read/Write;
// register-select controls Gra/Grb/Grc/Rin/Rout/BAout.
module control_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        run,
  output logic        illegal,
  output logic [4:0]  alu_op,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Zhighin,
  output logic        Zlowin,
  output logic        CONin,
  output logic        OutPortin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout
);
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_e;
  localparam logic [2:0] MW = 3'(MEM_WAIT);
  localparam logic [4:0] OP_ADD = 5'b00011;
  state_e state_q, state_d, last_step;
  logic [2:0] wait_q, wait_d;
  logic illegal_q, illegal_d;
  logic [4:0] op;
  logic is_ld, is_ldi, is_st, is_alu, is_imm, is_md, is_nn, is_br, is_jr;
  logic is_in, is_out, is_mflo, is_mfhi, is_nop, is_halt, is_ill, is_mem, hold;
  logic ir_unused;
  assign op = IR[31:27];
  assign ir_unused = ^IR[26:0];
  assign is_ld   = op == 5'd0;
  assign is_ldi  = op == 5'd1;
  assign is_st   = op == 5'd2;
  assign is_alu  = op >= 5'd3 && op <= 5'd11;
  assign is_imm  = op >= 5'd12 && op <= 5'd14;
  assign is_md   = op == 5'd15 || op == 5'd16;
  assign is_nn   = op == 5'd17 || op == 5'd18;
  assign is_br   = op == 5'd19;
  assign is_jr   = op == 5'd20;
  assign is_in   = op == 5'd22;
  assign is_out  = op == 5'd23;
  assign is_mflo = op == 5'd24;
  assign is_mfhi = op == 5'd25;
  assign is_nop  = op == 5'd26;
  assign is_halt = op == 5'd27;
  assign is_ill  = !(is_ld | is_ldi | is_st | is_alu | is_imm | is_md | is_nn | is_br | is_jr |
                     is_in | is_out | is_mflo | is_mfhi | is_nop | is_halt);
  // Steps that hold a memory strobe for MEM_WAIT extra cycles.
  assign is_mem = state_q == T1 || (state_q == T6 && is_ld) || (state_q == T7 && is_st);
  assign hold = is_mem && wait_q != 3'd0;
  assign last_step = (is_alu | is_imm | is_ldi) ? T5 :
                     is_nn ? T4 :
                     (is_md | is_br) ? T6 :
                     (is_ld | is_st) ? T7 : T3;
  always_comb begin
    state_d = state_q;
    wait_d = MW;
    illegal_d = illegal_q;
    case (state_q)
      T0: state_d = stop ? HALT : T1;
      HALT: state_d = HALT;
      default:
        if (hold) begin
          wait_d = wait_q - 3'd1;
        end else if (state_q == T3 && (is_halt || is_ill)) begin
          state_d = HALT;
          illegal_d = illegal_q | is_ill;
        end else if (state_q == last_step || state_q == T7) begin
          state_d = T0;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
    endcase
  end
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= T0;
      wait_q <= 3'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      illegal_q <= illegal_d;
    end
  end
  assign run = clear && state_q != HALT;
  assign illegal = clear && illegal_q;
  always_comb begin
    {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, CONin, OutPortin} = '0;
    {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    alu_op = '0;
    if (clear) begin
      case (state_q)
        T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          Zlowin = 1'b1;
        end
        T1: begin
          Zlowout = 1'b1;
          Read = 1'b1;
          MDRin = 1'b1;
          // Load the incremented PC only once, in the first cycle of the read.
          PCin = wait_q == MW;
        end
        T2: begin
          MDRout = 1'b1;
          IRin = 1'b1;
        end
        T3: begin
          if (is_alu | is_imm | is_md | is_ld | is_ldi | is_st) begin
            Rout = 1'b1;
            Yin = 1'b1;
            Gra = is_md;
            Grb = !is_md;
            BAout = is_ld | is_ldi | is_st;
          end else if (is_nn) begin
            Grb = 1'b1;
            Rout = 1'b1;
            alu_op = op;
            Zlowin = 1'b1;
          end else if (is_br | is_jr | is_out) begin
            Gra = 1'b1;
            Rout = 1'b1;
            CONin = is_br;
            PCin = is_jr;
            OutPortin = is_out;
          end else if (is_in | is_mflo | is_mfhi) begin
            InPortout = is_in;
            LOout = is_mflo;
            HIout = is_mfhi;
            Gra = 1'b1;
            Rin = 1'b1;
          end
        end
        T4: begin
          if (is_alu | is_imm) begin
            Grc = is_alu;
            Rout = is_alu;
            Cout = is_imm;
            alu_op = op;
            Zlowin = 1'b1;
          end else if (is_nn) begin
            Zlowout = 1'b1;
            Gra = 1'b1;
            Rin = 1'b1;
          end else if (is_md) begin
            Grb = 1'b1;
            Rout = 1'b1;
            alu_op = op;
            Zhighin = 1'b1;
            Zlowin = 1'b1;
          end else if (is_ld | is_ldi | is_st) begin
            Cout = 1'b1;
            alu_op = OP_ADD;
            Zlowin = 1'b1;
          end else if (is_br) begin
            PCout = 1'b1;
            Yin = 1'b1;
          end
        end
        T5: begin
          if (is_alu | is_imm | is_ldi) begin
            Zlowout = 1'b1;
            Gra = 1'b1;
            Rin = 1'b1;
          end else if (is_md | is_ld | is_st) begin
            Zlowout = 1'b1;
            LOin = is_md;
            MARin = !is_md;
          end else if (is_br) begin
            Cout = 1'b1;
            alu_op = OP_ADD;
            Zlowin = 1'b1;
          end
        end
        T6: begin
          if (is_md) begin
            Zhighout = 1'b1;
            HIin = 1'b1;
          end else if (is_ld) begin
            Read = 1'b1;
            MDRin = 1'b1;
          end else if (is_st) begin
            Gra = 1'b1;
            Rout = 1'b1;
            MDRin = 1'b1;
          end else if (is_br) begin
            Zlowout = 1'b1;
            PCin = CON;
          end
        end
        T7: begin
          if (is_ld) begin
            MDRout = 1'b1;
            Gra = 1'b1;
            Rin = 1'b1;
          end else if (is_st) begin
            Write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
